// File: rtl/zip_rr_arbiter.sv
// zip_rr_arbiter: two-channel, packet-granular round-robin arbiter feeding the
// 4:1 sample packer. Tags each beat with its source channel and, when the
// ZIP_ARB_PAD_EN macro is defined, zero-fills any packet that ends partway
// through a packer group so that groups never straddle packet boundaries.
// With ZIP_ARB_PAD_EN undefined, misaligned packets pass through unpadded and
// pad_events counts them as errors.
`timescale 1ns/1ps

module zip_rr_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4,   // power of two, >= 2
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i0_tdata,
  input  logic             i0_tlast,
  input  logic             i0_tvalid,
  output logic             i0_tready,
  input  logic [WIDTH-1:0] i1_tdata,
  input  logic             i1_tlast,
  input  logic             i1_tvalid,
  output logic             i1_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_tdest,
  output logic [CNT_W-1:0] pad_events,
  output logic             busy
);

  localparam int unsigned     PH_W    = $clog2(GROUP);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(GROUP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ZIP_ARB_PAD_EN
    S_PAD  = 2'd2,
`endif
    S_PASS = 2'd1
  } state_t;

  state_t            r_state;
  logic              r_grant;
  logic              r_last;
  logic [PH_W-1:0]   r_phase;
  logic [CNT_W-1:0]  r_pad_events;

  state_t            w_state_nxt;
  logic              w_grant_nxt;
  logic              w_last_nxt;
  logic [PH_W-1:0]   w_phase_nxt;
  logic [CNT_W-1:0]  w_pad_nxt;

  logic [WIDTH-1:0]  w_in_data;
  logic              w_in_last;
  logic              w_in_valid;
  logic              w_ph_end;
  logic              w_pad_sat;

  // Granted-channel input mux (zero-latency pass-through path)
  assign w_in_data  = r_grant ? i1_tdata  : i0_tdata;
  assign w_in_last  = r_grant ? i1_tlast  : i0_tlast;
  assign w_in_valid = r_grant ? i1_tvalid : i0_tvalid;
  assign w_ph_end   = (r_phase == PH_LAST);
  assign w_pad_sat  = (r_pad_events == CNT_MAX);

  assign o_tdest    = r_grant;
  assign pad_events = r_pad_events;
  assign busy       = (r_state != S_IDLE);

  // State, grant, round-robin pointer, group phase and pad-event counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last       <= 1'b1;
      r_phase      <= '0;
      r_pad_events <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last       <= w_last_nxt;
      r_phase      <= w_phase_nxt;
      r_pad_events <= w_pad_nxt;
    end
  end

  // Next-state logic and stream-side outputs
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_phase_nxt = r_phase;
    w_pad_nxt   = r_pad_events;
    o_tvalid    = 1'b0;
    o_tdata     = '0;
    o_tlast     = 1'b0;
    i0_tready   = 1'b0;
    i1_tready   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // On contention the channel not served last wins; otherwise the lone requester
        if (i0_tvalid || i1_tvalid) begin
          w_grant_nxt = (i0_tvalid && i1_tvalid) ? ~r_last : i1_tvalid;
          w_state_nxt = S_PASS;
        end
      end

      S_PASS: begin
        o_tvalid  = w_in_valid;
        o_tdata   = w_in_data;
        i0_tready = ~r_grant & o_tready;
        i1_tready =  r_grant & o_tready;
`ifdef ZIP_ARB_PAD_EN
        o_tlast   = w_in_last & w_ph_end;
`else
        o_tlast   = w_in_last;
`endif
        if (w_in_valid && o_tready) begin
          // phase wraps naturally because GROUP is a power of two
          w_phase_nxt = r_phase + PH_W'(1);
          if (w_in_last) begin
            if (w_ph_end) begin
              w_last_nxt  = r_grant;
              w_state_nxt = S_IDLE;
            end else begin
              if (!w_pad_sat) begin
                w_pad_nxt = r_pad_events + CNT_W'(1);
              end
`ifdef ZIP_ARB_PAD_EN
              w_state_nxt = S_PAD;
`else
              // Misaligned end passes straight through; restart the group count
              w_phase_nxt = '0;
              w_last_nxt  = r_grant;
              w_state_nxt = S_IDLE;
`endif
            end
          end
        end
      end

`ifdef ZIP_ARB_PAD_EN
      S_PAD: begin
        // Zero samples until the group closes; the closing beat carries tlast
        o_tvalid = 1'b1;
        o_tlast  = w_ph_end;
        if (o_tready) begin
          w_phase_nxt = r_phase + PH_W'(1);
          if (w_ph_end) begin
            w_last_nxt  = r_grant;
            w_state_nxt = S_IDLE;
          end
        end
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/zip_rr_arbiter.md
# zip_rr_arbiter

Two-channel, packet-granular round-robin arbiter in front of the 4:1 sample packer. Merges two 32-bit I/Q sample streams into the packer's single input and tags each beat with its source channel. Keeps every packet a whole number of packer groups: when a packet ends partway through a group, it fills the group with zero samples. This guarantees the packer never carries a partial group across a packet or channel boundary.

## Interface
- `WIDTH`, 32, sample width (16-bit I in [31:16], 16-bit Q in [15:0]).
- `GROUP`, 4, samples per packer output word; must be a power of two, ≥2.
- `CNT_W`, 16, width of the pad-event counter.

- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i0_tdata`  in  WIDTH  channel-0 sample.
- `i0_tlast`  in  1  channel-0 end of packet.
- `i0_tvalid`  in  1  channel-0 valid.
- `i0_tready`  out  1  channel-0 ready.
- `i1_tdata`, `i1_tlast`, `i1_tvalid`, `i1_tready`: same as channel 0, for channel 1.
- `o_tdata`  out  WIDTH  sample to the packer.
- `o_tlast`  out  1  end of packet to the packer.
- `o_tvalid`  out  1  output valid.
- `o_tready`  in  1  packer ready.
- `o_tdest`  out  1  source channel of the current beat.
- `pad_events`  out  CNT_W  number of packets that required padding; saturates at all-ones.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- State machine has three states: IDLE, PASS, PAD.
- **IDLE**
  - Outputs: `o_tvalid`=0, `i0_tready`=`i1_tready`=0.
  - If any `iX_tvalid` is high, register a grant and go to PASS.
  - If both are valid, grant the channel other than `last`.
  - `last` is the most recently granted channel and resets to 1, so channel 0 wins first.
- **PASS**
  - `o_tdata`/`o_tvalid` come combinationally from the granted channel.
  - Granted `iX_tready` = `o_tready`; the non-granted ready is 0.
  - `o_tdest` = grant.
  - `phase` (log2(GROUP) bits) increments on every accepted output beat and wraps modulo GROUP.
- **End of packet in PASS** (input tlast accepted):
  - If `phase` == GROUP-1: `o_tlast`=1, `phase`→0, `last`←grant, go to IDLE.
  - Otherwise: `o_tlast`=0 on that beat, go to PAD, `pad_events`+1 (saturating).
- **PAD**
  - Outputs: `o_tvalid`=1, `o_tdata`=0, `o_tdest`=grant, both input readies 0.
  - Each accepted beat increments `phase`.
  - The beat with `phase` == GROUP-1 carries `o_tlast`=1; then `phase`→0, `last`←grant, go to IDLE.
  - Number of pad beats = GROUP-1-phase_at_tlast.
- Grant does not change mid-packet or mid-pad. Valid on the other channel never preempts.
- `o_tvalid`, once high, stays high with data stable until accepted (AXI-Stream rule). In PASS this is inherited from the upstream source.

## Timing
- **Reset values:** state IDLE, grant 0, `last` 1, `phase` 0, `pad_events` 0. Outputs `o_tvalid`=0, `o_tlast`=0, `o_tdest`=0, `busy`=0, both readies 0.
- Arbitration costs exactly one IDLE cycle per packet. The first beat of a granted packet can be accepted in the cycle after the grant.
- PASS has zero latency input→output. There is no internal buffering.
- The PAD→IDLE→PASS sequence always includes the one IDLE cycle.
- A packet of length 1 with `phase`=0 produces one data beat plus GROUP-1 pad beats.
- `o_tready` low holds the state; `phase` and counters do not advance.
- Reset assertion mid-packet immediately forces all reset values. The partially transferred packet is abandoned.

## Configuration
- Macro: `ZIP_ARB_PAD_EN`.
- **Defined:** padding behaves as described above.
- **Undefined:**
  - The PAD state is not built.
  - A misaligned input tlast passes through with `o_tlast`=1, `phase`→0, and the FSM goes to IDLE.
  - `pad_events` counts misaligned packets, as an error count.

## Test plan
- **Single channel, aligned:** ch0 sends 8 samples 0x00010001..0x00080008, tlast on the 8th, `o_tready`=1 → 8 beats out, `o_tdest`=0, `o_tlast` on the 8th, `pad_events`=0.
- **Misaligned, pad enabled:** ch1 sends 6 samples, tlast on the 6th → 6 data beats, then 2 zero beats, `o_tlast` on the 8th only, `o_tdest`=1, `pad_events`=1. Without the macro: `o_tlast` on the 6th beat, and `pad_events`=1.
- **Contention:** both channels continuously valid with 4-sample packets → grants alternate 0,1,0,1 starting with 0. One idle cycle between packets.
- **Backpressure:** toggle `o_tready` every cycle during ch0 PASS and PAD → no lost or duplicated beats, data stable while stalled, same total beats as with `o_tready`=1.
- **Saturation:** with `CNT_W`=2, send 5 misaligned packets → `pad_events` holds 3.
- **Reset mid-packet:** drop `reset_n` after 2 beats of a ch1 packet → outputs go to reset values asynchronously. After release, ch0 wins the first arbitration with `phase`=0.
